// File: rtl/saph_fpi_if.sv
// GPU<->FPU request/result link. The FPU port reads `latency` to know when the
// GPU side will sample the result.
interface saph_fpi #(
    parameter int latency = 1
) ();
    logic        d_trig;
    logic        d_ready;
    logic [1:0]  d_mode;
    logic [31:0] d_lhs;
    logic [31:0] d_rhs;
    logic [3:0]  has_modes;
    logic        q_trig;
    logic [31:0] q_res;

    modport GPU (output d_trig, d_mode, d_lhs, d_rhs,
                 input  d_ready, has_modes, q_trig, q_res);
    modport FPU (input  d_trig, d_mode, d_lhs, d_rhs,
                 output d_ready, has_modes, q_trig, q_res);
endinterface

// File: rtl/saph_fpu_iter.sv
// Iterative binary32 mul/div FPU port: shift-add multiplier, restoring divider,
// truncating, flush-to-zero. Result pulses at max(28, latency) cycles after accept.
module saph_fpu_iter (
    input  logic   clk,
    input  logic   rst,
    saph_fpi.FPU   fpi
);
    localparam int L    = fpi.latency;
    localparam int ITER = 25;
    localparam int TGT  = (L > 28) ? L : 28;
    localparam int LW   = $clog2(TGT + 1);

    typedef enum logic [2:0] {IDLE, UNPACK, ITER_S, NORM, DONE} state_t;
    state_t state, state_nx;

    logic          accept, fire, iter_last;
    logic          op_div, sgn;
    logic [31:0]   a_r, b_r;
    logic [7:0]    ea, eb;
    logic [23:0]   ma_c, mb_c, mb_r;
    logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [4:0]    iter_cnt;
    logic [LW-1:0] lat_cnt;
    logic [47:0]   acc, mcand;
    logic [23:0]   mplier;
    logic [25:0]   rem;
    logic [24:0]   quo;
    logic [31:0]   res_r, res_nx, q_hold;
    logic signed [9:0] e_res;
    logic [22:0]   frac;

    assign accept    = fpi.d_trig && (state == IDLE) && fpi.d_mode[1];
    assign iter_last = (iter_cnt == 5'(ITER - 1));
    assign ma_c      = (a_r[30:23] == 8'd0) ? 24'd0 : {1'b1, a_r[22:0]};
    assign mb_c      = (b_r[30:23] == 8'd0) ? 24'd0 : {1'b1, b_r[22:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = UNPACK;
            UNPACK:  state_nx = ITER_S;
            ITER_S:  if (iter_last) state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    if (fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        fire          = (state == DONE) && (lat_cnt >= LW'(TGT));
        fpi.d_ready   = (state == IDLE);
        fpi.q_trig    = fire;
        fpi.q_res     = fire ? res_r : q_hold;
        fpi.has_modes = 4'b1100;
    end

    // Normalise + exponent + specials; specials override the arithmetic path.
    always_comb begin
        if (op_div) begin
            e_res = 10'({2'b0, ea}) - 10'({2'b0, eb}) + 10'd127 - {9'd0, ~quo[24]};
            frac  = quo[24] ? quo[23:1] : quo[22:0];
        end else begin
            e_res = 10'({2'b0, ea}) + 10'({2'b0, eb}) - 10'd127 + {9'd0, acc[47]};
            frac  = acc[47] ? acc[46:24] : acc[45:23];
        end
        if (e_res >= 10'sd255)   res_nx = {sgn, 8'hFF, 23'd0};
        else if (e_res <= 10'sd0) res_nx = {sgn, 31'd0};
        else                     res_nx = {sgn, e_res[7:0], frac};
        if (op_div) begin
            if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) res_nx = 32'h7FC00000;
            else if (zero_b)         res_nx = {sgn, 8'hFF, 23'd0};
            else if (inf_b || zero_a) res_nx = {sgn, 31'd0};
            else if (inf_a)          res_nx = {sgn, 8'hFF, 23'd0};
        end else begin
            if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) res_nx = 32'h7FC00000;
            else if (inf_a || inf_b)   res_nx = {sgn, 8'hFF, 23'd0};
            else if (zero_a || zero_b) res_nx = {sgn, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_div <= 1'b0; sgn <= 1'b0; a_r <= '0; b_r <= '0;
            ea <= '0; eb <= '0; mb_r <= '0;
            zero_a <= 1'b0; zero_b <= 1'b0; inf_a <= 1'b0; inf_b <= 1'b0;
            nan_a <= 1'b0; nan_b <= 1'b0;
            iter_cnt <= '0; lat_cnt <= '0;
            acc <= '0; mcand <= '0; mplier <= '0; rem <= '0; quo <= '0;
            res_r <= '0; q_hold <= '0;
        end else begin
            if (state == IDLE) begin
                lat_cnt <= accept ? LW'(1) : '0;
                if (accept) begin
                    op_div <= fpi.d_mode[0];
                    a_r    <= fpi.d_lhs;
                    b_r    <= fpi.d_rhs;
                end
            end else begin
                lat_cnt <= lat_cnt + LW'(1);
            end
            case (state)
                UNPACK: begin
                    sgn    <= a_r[31] ^ b_r[31];
                    ea     <= a_r[30:23];
                    eb     <= b_r[30:23];
                    zero_a <= (a_r[30:23] == 8'd0);
                    zero_b <= (b_r[30:23] == 8'd0);
                    inf_a  <= (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
                    inf_b  <= (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
                    nan_a  <= (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
                    nan_b  <= (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
                    mb_r   <= mb_c;
                    acc    <= '0;
                    mcand  <= {24'd0, ma_c};
                    mplier <= mb_c;
                    rem    <= {2'b0, ma_c};
                    quo    <= '0;
                    iter_cnt <= '0;
                end
                ITER_S: begin
                    iter_cnt <= iter_last ? 5'd0 : iter_cnt + 5'd1;
                    if (op_div) begin
                        if (rem >= {2'b0, mb_r}) begin
                            quo <= {quo[23:0], 1'b1};
                            rem <= (rem - {2'b0, mb_r}) << 1;
                        end else begin
                            quo <= {quo[23:0], 1'b0};
                            rem <= rem << 1;
                        end
                    end else if (!iter_last) begin
                        // one multiplier bit per cycle; the final slot is idle
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                NORM: res_r <= res_nx;
                DONE: if (fire) q_hold <= res_r;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_saph_fpu_iter.sv
// Bench for saph_fpu_iter: one DUT at latency 4, one at latency 40,
// expected results queued on issue and popped on q_trig.
module tb_saph_fpu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    saph_fpi #(.latency(4))  f4 ();
    saph_fpi #(.latency(40)) f40 ();

    saph_fpu_iter u4  (.clk(clk), .rst(rst), .fpi(f4));
    saph_fpu_iter u40 (.clk(clk), .rst(rst), .fpi(f40));

    task automatic set_in(input bit lng, input logic trig, input logic [1:0] m,
                          input logic [31:0] a, input logic [31:0] b);
        if (lng) begin
            f40.d_trig = trig; f40.d_mode = m; f40.d_lhs = a; f40.d_rhs = b;
        end else begin
            f4.d_trig = trig; f4.d_mode = m; f4.d_lhs = a; f4.d_rhs = b;
        end
    endtask

    function automatic logic rd_ready(input bit lng);
        return lng ? f40.d_ready : f4.d_ready;
    endfunction
    function automatic logic rd_trig(input bit lng);
        return lng ? f40.q_trig : f4.q_trig;
    endfunction
    function automatic logic [31:0] rd_res(input bit lng);
        return lng ? f40.q_res : f4.q_res;
    endfunction

    // Issue one op and watch every cycle until two cycles past the expected pulse.
    task automatic do_op(input string nm, input bit lng, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int poke);
        int tgt;
        logic [31:0] want;
        tgt = lng ? 40 : 28;
        sb.push_back(exp_r);
        set_in(lng, 1'b1, m, a, b);
        for (int c = 1; c <= tgt + 2; c++) begin
            @(negedge clk);
            if (c == 1 || c == poke + 1) set_in(lng, 1'b0, m, a, b);
            if (c == poke) set_in(lng, 1'b1, 2'd2, 32'h3F800000, 32'h3F800000);
            total++;
            if (rd_ready(lng) !== (c > tgt)) begin
                bad++;
                $display("FAIL %s d_ready cyc %0d: got %b want %b", nm, c, rd_ready(lng), c > tgt);
            end
            total++;
            if (rd_trig(lng) !== (c == tgt)) begin
                bad++;
                $display("FAIL %s q_trig cyc %0d: got %b want %b", nm, c, rd_trig(lng), c == tgt);
            end
            if (rd_trig(lng) === 1'b1 && sb.size() > 0) begin
                want = sb.pop_front();
                total++;
                if (rd_res(lng) !== want) begin
                    bad++;
                    $display("FAIL %s q_res: got %h want %h", nm, rd_res(lng), want);
                end
            end
            if (c > tgt) begin
                total++;
                if (rd_res(lng) !== exp_r) begin
                    bad++;
                    $display("FAIL %s q_res hold cyc %0d: got %h want %h", nm, c, rd_res(lng), exp_r);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s no result: pending %0d want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (f4.d_ready !== 1'b1 || f4.q_trig !== 1'b0 || f4.q_res !== 32'd0) begin
            bad++;
            $display("FAIL reset4: got %b %b %h want 1 0 00000000", f4.d_ready, f4.q_trig, f4.q_res);
        end
        total++;
        if (f40.d_ready !== 1'b1 || f40.q_trig !== 1'b0 || f40.q_res !== 32'd0) begin
            bad++;
            $display("FAIL reset40: got %b %b %h want 1 0 00000000", f40.d_ready, f40.q_trig, f40.q_res);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_div();
        do_op("mul2x3", 0, 2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, -5);
        do_op("div1by3", 0, 2'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, -5);
        do_op("mulneg", 0, 2'd2, 32'hC0000000, 32'h3FC00000, 32'hC0400000, -5);
        do_op("div6by2", 0, 2'd3, 32'h40C00000, 32'h40000000, 32'h40400000, -5);
    endtask

    task automatic test_specials();
        do_op("inf_x_0", 0, 2'd2, 32'h7F800000, 32'h00000000, 32'h7FC00000, -5);
        do_op("m1_div_0", 0, 2'd3, 32'hBF800000, 32'h00000000, 32'hFF800000, -5);
        do_op("ovf", 0, 2'd2, 32'h7F000000, 32'h7F000000, 32'h7F800000, -5);
        do_op("unf", 0, 2'd2, 32'h00800000, 32'h00800000, 32'h00000000, -5);
        do_op("nan_in", 0, 2'd3, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, -5);
        do_op("x_div_inf", 0, 2'd3, 32'h3F800000, 32'hFF800000, 32'h80000000, -5);
    endtask

    task automatic test_long_latency();
        do_op("long", 1, 2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, -5);
    endtask

    task automatic test_ignored();
        do_op("drop10", 0, 2'd2, 32'h40000000, 32'h40000000, 32'h40800000, 10);
        set_in(0, 1'b1, 2'd0, 32'h3F800000, 32'h3F800000);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) set_in(0, 1'b0, 2'd0, 32'h0, 32'h0);
            total++;
            if (f4.d_ready !== 1'b1 || f4.q_trig !== 1'b0) begin
                bad++;
                $display("FAIL mode0 cyc %0d: got rdy=%b trig=%b want rdy=1 trig=0", c, f4.d_ready, f4.q_trig);
            end
        end
        total++;
        if (f4.has_modes !== 4'b1100 || f40.has_modes !== 4'b1100) begin
            bad++;
            $display("FAIL has_modes: got %b %b want 1100", f4.has_modes, f40.has_modes);
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 1'b1, 2'd2, 32'h40000000, 32'h40400000);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) set_in(0, 1'b0, 2'd2, 32'h0, 32'h0);
            total++;
            if (f4.has_modes !== 4'b1100) begin
                bad++;
                $display("FAIL has_modes busy: got %b want 1100", f4.has_modes);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (f4.d_ready !== 1'b1 || f4.q_trig !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got rdy=%b trig=%b want rdy=1 trig=0", f4.d_ready, f4.q_trig);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            total++;
            if (f4.q_trig !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid stray q_trig: got %b want 0", f4.q_trig);
            end
        end
        do_op("after_rst", 0, 2'd2, 32'h40400000, 32'h40400000, 32'h41100000, -5);
    endtask

    initial begin
        set_in(0, 1'b0, 2'd0, 32'h0, 32'h0);
        set_in(1, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        test_reset();
        test_mul_div();
        test_specials();
        test_long_latency();
        test_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/saph_fpu_iter.md
# saph_fpu_iter

Iterative single-precision multiply/divide unit that sits on the FPU side of a `saph_fpi` link, as one of the FPU ports behind the FPU demultiplexer. It accepts one request at a time and runs a shift-add multiplier or a restoring divider for a fixed number of cycles. It returns the result with a one-cycle `q_trig` pulse no earlier than the interface latency after acceptance. When the pulse is later than that latency, the GPU side stalls.

## Interface
- `L`, from `fpi.latency` (no module parameter): cycles the GPU side expects between acceptance and result; must be ≥1.
- `ITER`, 25: iteration cycles per operation; localparam, not overridable.
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `fpi` modport `saph_fpi.FPU`, with these signals:
  - `d_trig` in 1: request strobe.
  - `d_ready` out 1: unit can accept a request.
  - `d_mode` in 2: operation; 0 add, 1 sub, 2 mul, 3 div.
  - `d_lhs` in 32: IEEE-754 binary32 operand.
  - `d_rhs` in 32: IEEE-754 binary32 operand.
  - `has_modes` out 4: constant 4'b1100 (mul and div only).
  - `q_trig` out 1: result-valid pulse.
  - `q_res` out 32: result.

## Operation
- **Acceptance:**
  - A request is accepted on an edge where `d_trig && d_ready && d_mode[1]`.
  - `d_trig` with mode 0 or 1 is ignored and gets no response.
  - Operands and mode are registered on the accepting edge; inputs are don't-care afterwards.
- **States:**
  - IDLE: `d_ready`=1. On accept go to UNPACK.
  - UNPACK: 1 cycle. Split sign, exponent and mantissa, add the implicit 1, flush denormal inputs to zero, classify specials. Go to ITER.
  - ITER: exactly 25 cycles, counter counts 0..24.
    - mul: 24-bit × 24-bit shift-add into a 48-bit product, one multiplier bit per cycle; cycle 24 idles.
    - div: restoring division producing 25 quotient bits of ma/mb.
    - Go to NORM.
  - NORM: 1 cycle. Normalise, compute the exponent, truncate (round toward zero), apply specials. Go to DONE.
  - DONE: hold the result. Pulse `q_trig` for one cycle when the latency counter allows (see Timing), then go to IDLE.
- **Exponent arithmetic:** 10-bit signed.
  - mul: ea+eb−127, +1 if product bit 47 is set.
  - div: ea−eb+127, −1 if quotient bit 24 is clear.
  - Result ≥255 → ±inf. Result ≤0 → ±0 (flush to zero, no denormal outputs).
- **Sign:** sa^sb for all results except NaN.
- **Specials:** take priority over the arithmetic result.
  - Any NaN input → 0x7FC00000.
  - mul: inf×0 → 0x7FC00000; inf×finite → ±inf; 0×finite → ±0.
  - div: 0/0 and inf/inf → 0x7FC00000; x/0 → ±inf; x/inf → ±0; 0/x → ±0; inf/x → ±inf.
- **Reset:**
  - Output values: `d_ready`=1, `q_trig`=0, `q_res`=0, state IDLE, all counters 0.
  - Reset in any state aborts the operation; no `q_trig` for that request.
- **Output hold:** `q_res` holds its last value outside the `q_trig` cycle.

## Timing
- Cycle 0 is the accepting edge.
- States by cycle: UNPACK in cycle 1, ITER in cycles 2–26, NORM in cycle 27, result registered for cycle 28.
- A latency counter starts at acceptance. `q_trig`=1 in exactly cycle max(28, L), for one cycle.
  - Early results wait in DONE.
  - Same timing for special-case operands (no early out).
- `d_ready`=0 from cycle 1 through the `q_trig` cycle. It returns to 1 in the cycle after `q_trig`.
- Throughput is one operation per max(28, L)+1 cycles.
- `d_trig` while `d_ready`=0 is ignored. This includes the `q_trig` cycle.

## Test plan
- **Multiply:** L=4, mul 0x40000000 × 0x40400000 → `q_trig` exactly at cycle 28, `q_res`=0x40C00000; `d_ready` low cycles 1–28, high at 29.
- **Divide:** L=4, div 0x3F800000 / 0x40400000 → 0x3EAAAAAA (truncated) at cycle 28.
- **Specials, one request each:**
  - inf×0 (0x7F800000 × 0x00000000) → 0x7FC00000.
  - 0xBF800000 / 0x00000000 → 0xFF800000.
  - 0x7F000000 × 0x7F000000 → 0x7F800000.
  - 0x00800000 × 0x00800000 → 0x00000000.
  - Each at cycle 28.
- **Long latency:** L=40, mul 0x3FC00000 × 0x40000000 → `q_trig` at cycle 40 only, `q_res`=0x40400000, no pulse at 28.
- **Ignored requests:**
  - A second `d_trig` at cycle 10 is dropped; only one `q_trig`.
  - A `d_trig` with mode 0 while idle gets no response, and `d_ready` stays 1.
  - `has_modes` reads 4'b1100 at all times.
- **Reset mid-operation:**
  - Assert `rst` at cycle 15 → `d_ready`=1 and `q_trig`=0 the next cycle, no pulse afterwards.
  - A new mul started after reset returns the correct result at its cycle 28.
